regfile_mp: RTL and testbench

- Parametrised successor to the single-write, two-read ARM register file; sits in the datapath between decode and the ALU/memory stages of the multicycle core.
- Provides N combinational read ports with PC-as-register substitution and two write ports: a general write and a load/link write.
- Adds optional same-cycle write-to-read bypass and a per-register pending-load scoreboard, so the controller can stall on registers with outstanding multicycle loads.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 53 +++++
 rtl/regfile_mp.sv | 99 +++++++++
 tb/tb_regfile_mp.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// Defaults match the ARM-style 16-entry file with r15 as PC and r14 as LR.
package regfile_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int NREGS_DEF   = 16;
    localparam int RIDX_DEF    = $clog2(NREGS_DEF);
    localparam int PC_IDX      = NREGS_DEF - 1;
    localparam int LR_IDX      = 14;
    localparam int LINK_OFFSET = 4;

    typedef logic [RIDX_DEF-1:0] reg_idx_t;
    typedef logic [XLEN_DEF-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register (PC excluded),
// set by load issue, cleared by load writeback, plus per-read-port busy lookup.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 3,
    parameter  int BYPASS = 1,
    localparam int RIDX   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_issue,
    input  logic [RIDX-1:0]     ld_dst,
    input  logic                we1,
    input  logic [RIDX-1:0]     wa1,
    input  logic [NRD*RIDX-1:0] ra,
    output logic [NRD-1:0]      rd_busy,
    output logic [NREGS-1:0]    busy_vec
);

    logic [NREGS-2:0] pending;

    // A new load to the same register replaces the one being retired, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int j = 0; j < NREGS - 1; j++) begin
                if (ld_issue && ld_dst == RIDX'(j))
                    pending[j] <= 1'b1;
                else if (we1 && wa1 == RIDX'(j))
                    pending[j] <= 1'b0;
            end
        end
    end

    assign busy_vec = {1'b0, pending};

    always_comb begin
        logic [RIDX-1:0] idx;
        rd_busy = '0;
        idx     = '0;
        for (int p = 0; p < NRD; p++) begin
            idx = ra[p*RIDX +: RIDX];
            for (int j = 0; j < NREGS - 1; j++) begin
                if (idx == RIDX'(j))
                    rd_busy[p] = pending[j] && !((BYPASS != 0) && we1 && wa1 == idx);
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD combinational reads with PC substitution,
// general + load/link write ports, optional write bypass and pending-load scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int NRD    = 3,
    parameter  int LR_IDX = regfile_pkg::LR_IDX,
    parameter  int BYPASS = 1,
    localparam int RIDX   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*RIDX-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rd_busy,
    input  logic [XLEN-1:0]     pc_plus8,
    input  logic                we0,
    input  logic [RIDX-1:0]     wa0,
    input  logic [XLEN-1:0]     wd0,
    input  logic                we1,
    input  logic [RIDX-1:0]     wa1,
    input  logic [XLEN-1:0]     wd1,
    input  logic                link,
    input  logic                ld_issue,
    input  logic [RIDX-1:0]     ld_dst,
    output logic [NREGS-1:0]    busy_vec
);

    localparam int PC = NREGS - 1;

    // No storage for the PC slot: writes addressed there simply find no register.
    logic [XLEN-1:0] regs [NREGS-1];
    logic [XLEN-1:0] link_val;

    assign link_val = pc_plus8 - XLEN'(LINK_OFFSET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < PC; r++)
                regs[r] <= '0;
        end else begin
            for (int r = 0; r < PC; r++) begin
                if (link && r == LR_IDX)
                    regs[r] <= link_val;
                else if (we1 && wa1 == RIDX'(r))
                    regs[r] <= wd1;
                else if (we0 && wa0 == RIDX'(r))
                    regs[r] <= wd0;
            end
        end
    end

    // Bypass is suppressed in reset so reads see the cleared file, not pending writes.
    always_comb begin
        logic [RIDX-1:0] idx;
        logic            byp;
        rd  = '0;
        idx = '0;
        byp = (BYPASS != 0) && rst_n;
        for (int p = 0; p < NRD; p++) begin
            idx = ra[p*RIDX +: RIDX];
            if (idx == RIDX'(PC)) begin
                rd[p*XLEN +: XLEN] = pc_plus8;
            end else begin
                for (int r = 0; r < PC; r++) begin
                    if (idx == RIDX'(r)) begin
                        if (byp && link && r == LR_IDX)
                            rd[p*XLEN +: XLEN] = link_val;
                        else if (byp && we1 && wa1 == idx)
                            rd[p*XLEN +: XLEN] = wd1;
                        else if (byp && we0 && wa0 == idx)
                            rd[p*XLEN +: XLEN] = wd0;
                        else
                            rd[p*XLEN +: XLEN] = regs[r];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .we1      (we1),
        .wa1      (wa1),
        .ra       (ra),
        .rd_busy  (rd_busy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus randomized traffic checked
// against an array-based reference model of the register file and scoreboard.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 16;
    localparam int NRD   = 3;
    localparam int RIDX  = 4;
    localparam int PC    = 15;
    localparam int LR    = 14;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*RIDX-1:0] ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      rd_busy;
    logic [XLEN-1:0]     pc_plus8;
    logic                we0, we1, link, ld_issue;
    logic [RIDX-1:0]     wa0, wa1, ld_dst;
    logic [XLEN-1:0]     wd0, wd1;
    logic [NREGS-1:0]    busy_vec;

    int n_tests = 0;
    int n_fail  = 0;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra       (ra),
        .rd       (rd),
        .rd_busy  (rd_busy),
        .pc_plus8 (pc_plus8),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .link     (link),
        .ld_issue (ld_issue),
        .ld_dst   (ld_dst),
        .busy_vec (busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
        end
    endfunction

    // Value a read of idx should see now: stored value overridden by this cycle's
    // writes, lowest priority applied first so the highest priority lands last.
    function automatic logic [31:0] exp_rd(input int idx);
        logic [31:0] v;
        if (idx == PC) return pc_plus8;
        if (!rst_n) return 32'h0;
        v = m_regs[idx];
        if (we0 && int'(wa0) == idx) v = wd0;
        if (we1 && int'(wa1) == idx) v = wd1;
        if (link && idx == LR) v = pc_plus8 - 32'd4;
        return v;
    endfunction

    function automatic logic [31:0] exp_busy(input int idx);
        if (idx == PC || !rst_n) return 32'h0;
        if (we1 && int'(wa1) == idx) return 32'h0;
        return {31'h0, m_pend[idx]};
    endfunction

    function automatic logic [NREGS-1:0] exp_vec();
        logic [NREGS-1:0] v;
        v = '0;
        for (int i = 0; i < PC; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic void commit();
        for (int i = 0; i < PC; i++) m_regs[i] = exp_rd(i);
        if (we1 && int'(wa1) != PC) m_pend[wa1] = 1'b0;
        if (ld_issue && int'(ld_dst) != PC) m_pend[ld_dst] = 1'b1;
    endfunction

    task automatic check_all();
        int idx;
        for (int p = 0; p < NRD; p++) begin
            idx = int'(ra[p*RIDX +: RIDX]);
            chk($sformatf("rd%0d[r%0d]", p, idx), rd[p*XLEN +: XLEN], exp_rd(idx));
            chk($sformatf("rd_busy%0d[r%0d]", p, idx), {31'h0, rd_busy[p]}, exp_busy(idx));
        end
        chk("busy_vec", {16'h0, busy_vec}, {16'h0, exp_vec()});
    endtask

    task automatic idle();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        link = 0; ld_issue = 0; ld_dst = '0;
    endtask

    task automatic set_ra(input int a0, input int a1, input int a2);
        ra = {RIDX'(a2), RIDX'(a1), RIDX'(a0)};
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        commit();
        #1;
        idle();
    endtask

    initial begin
        rst_n = 0;
        pc_plus8 = 32'h100;
        idle();
        set_ra(0, 1, 15);
        model_reset();
        we0 = 1; wa0 = 4'd1; wd0 = 32'h5;
        #2;
        chk("reset_rd_r1", rd[63:32], 32'h0);
        chk("reset_rd_pc", rd[95:64], 32'h100);
        chk("reset_busy_vec", {16'h0, busy_vec}, 32'h0);
        check_all();
        idle();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // general write, bypass in the write cycle and stored value next cycle
        set_ra(3, 0, 15);
        we0 = 1; wa0 = 4'd3; wd0 = 32'hDEADBEEF;
        #1 chk("bypass_r3", rd[31:0], 32'hDEADBEEF);
        step();
        #1 chk("stored_r3", rd[31:0], 32'hDEADBEEF);
        step();

        // link beats we0 to LR; PC reads and PC writes
        pc_plus8 = 32'h108;
        set_ra(14, 15, 3);
        link = 1; we0 = 1; wa0 = 4'd14; wd0 = 32'h55;
        #1 chk("bypass_lr", rd[31:0], 32'h104);
        step();
        #1 chk("stored_lr", rd[31:0], 32'h104);
        chk("pc_read", rd[63:32], 32'h108);
        we0 = 1; wa0 = 4'd15; wd0 = 32'h77;
        #1 chk("pc_no_bypass", rd[63:32], 32'h108);
        step();

        // we1 beats we0 on the same index
        set_ra(5, 14, 15);
        we0 = 1; wa0 = 4'd5; wd0 = 32'h1;
        we1 = 1; wa1 = 4'd5; wd1 = 32'h2;
        #1 chk("bypass_r5_prio", rd[31:0], 32'h2);
        step();
        #1 chk("stored_r5_prio", rd[31:0], 32'h2);
        step();

        // load issue, busy for three cycles, writeback clears
        set_ra(7, 5, 15);
        ld_issue = 1; ld_dst = 4'd7;
        step();
        #1 chk("busy_vec7_set", {31'h0, busy_vec[7]}, 32'h1);
        chk("rd_busy_r7", {31'h0, rd_busy[0]}, 32'h1);
        step();
        step();
        we1 = 1; wa1 = 4'd7; wd1 = 32'hAA;
        #1 chk("rd_busy_r7_bypass_clear", {31'h0, rd_busy[0]}, 32'h0);
        step();
        #1 chk("busy_vec7_clear", {31'h0, busy_vec[7]}, 32'h0);
        chk("stored_r7", rd[31:0], 32'hAA);
        step();

        // set wins over clear on the same index
        set_ra(9, 7, 15);
        ld_issue = 1; ld_dst = 4'd9;
        we1 = 1; wa1 = 4'd9; wd1 = 32'h99;
        step();
        #1 chk("busy_vec9_set_wins", {31'h0, busy_vec[9]}, 32'h1);
        step();

        // asynchronous reset in the middle of a cycle
        set_ra(2, 4, 15);
        we0 = 1; wa0 = 4'd2; wd0 = 32'h1234;
        ld_issue = 1; ld_dst = 4'd4;
        step();
        chk("pre_reset_r2", rd[31:0], 32'h1234);
        chk("pre_reset_busy4", {31'h0, busy_vec[4]}, 32'h1);
        #2 rst_n = 0;
        model_reset();
        #1 chk("async_reset_r2", rd[31:0], 32'h0);
        chk("async_reset_busy_vec", {16'h0, busy_vec}, 32'h0);
        check_all();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            ra       = NRD*RIDX'($urandom);
            pc_plus8 = $urandom;
            we0      = 1'($urandom_range(0, 1));
            wa0      = RIDX'($urandom);
            wd0      = $urandom;
            we1      = 1'($urandom_range(0, 1));
            wa1      = RIDX'($urandom);
            wd1      = $urandom;
            link     = ($urandom_range(0, 3) == 0);
            ld_issue = 1'($urandom_range(0, 1));
            ld_dst   = RIDX'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
